// File: rtl/mem_arbiter.sv
// Fixed-priority (D over IF) arbiter for a unified byte-addressed memory port, with an IF
// starvation guard and address legality checking. Defining MEM_ARB_STATS_EN adds grant/stall counters.
module mem_arbiter #(
   parameter int unsigned       AWIDTH       = 32,
   parameter int unsigned       DWIDTH       = 32,
   parameter logic [AWIDTH-1:0] BASE_ADDR    = AWIDTH'(32'h0100_0000),
   parameter int unsigned       MEM_BYTES    = 65536,
   parameter int unsigned       STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [AWIDTH-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DWIDTH-1:0] if_rdata_o,
   output logic              if_err_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [AWIDTH-1:0] d_addr_i,
   input  logic [DWIDTH-1:0] d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [DWIDTH-1:0] d_rdata_o,
   output logic              d_err_o,
   output logic [AWIDTH-1:0] mem_addr_o,
   output logic [DWIDTH-1:0] mem_data_o,
   output logic              mem_read_en_o,
   output logic              mem_write_en_o,
   input  logic [DWIDTH-1:0] mem_data_i,
   output logic [31:0]       stat_if_cnt_o,
   output logic [31:0]       stat_d_cnt_o,
   output logic [31:0]       stat_stall_cnt_o
);

   localparam int unsigned EW = AWIDTH + 1;
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   // One extra bit so the window end cannot wrap for windows near the top of the address space.
   localparam logic [EW-1:0] ADDR_LO = {1'b0, BASE_ADDR};
   localparam logic [EW-1:0] ADDR_HI = ADDR_LO + EW'(MEM_BYTES) - EW'(4);

   logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic              if_err_q, if_err_d;
   logic [DWIDTH-1:0] if_rdata_q, if_rdata_d;
   logic              d_rvalid_q, d_rvalid_d;
   logic              d_err_q, d_err_d;
   logic [DWIDTH-1:0] d_rdata_q, d_rdata_d;

   logic              if_gnt, d_gnt;
   logic [AWIDTH-1:0] gnt_addr;
   logic              gnt_legal;
   logic              gnt_we;

   // Grant selection; nothing is granted while reset is asserted.
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (rst) begin
         if (if_req_i && (starve_cnt_q >= STARVE_MAX)) begin
            if_gnt = 1'b1;
         end else if (d_req_i) begin
            d_gnt = 1'b1;
         end else if (if_req_i) begin
            if_gnt = 1'b1;
         end
      end
   end

   // Legality check, memory port drive and next-cycle response.
   always_comb begin
      gnt_addr  = d_gnt ? d_addr_i : if_addr_i;
      gnt_we    = d_gnt & d_we_i;
      gnt_legal = (gnt_addr[1:0] == 2'b00)
                  && ({1'b0, gnt_addr} >= ADDR_LO)
                  && ({1'b0, gnt_addr} <= ADDR_HI);

      mem_addr_o     = BASE_ADDR;
      mem_data_o     = '0;
      mem_read_en_o  = 1'b0;
      mem_write_en_o = 1'b0;
      if ((if_gnt || d_gnt) && gnt_legal) begin
         mem_addr_o = gnt_addr;
         if (gnt_we) begin
            mem_write_en_o = 1'b1;
            mem_data_o     = d_wdata_i;
         end else begin
            mem_read_en_o = 1'b1;
         end
      end

      if_rvalid_d = if_gnt;
      if_err_d    = if_gnt & ~gnt_legal;
      if_rdata_d  = (if_gnt && gnt_legal) ? mem_data_i : '0;
      d_rvalid_d  = d_gnt;
      d_err_d     = d_gnt & ~gnt_legal;
      d_rdata_d   = (d_gnt && gnt_legal && !d_we_i) ? mem_data_i : '0;

      starve_cnt_d = '0;
      if (if_req_i && !if_gnt) begin
         starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q : starve_cnt_q + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt_q <= '0;
         if_rvalid_q  <= 1'b0;
         if_err_q     <= 1'b0;
         if_rdata_q   <= '0;
         d_rvalid_q   <= 1'b0;
         d_err_q      <= 1'b0;
         d_rdata_q    <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         if_rvalid_q  <= if_rvalid_d;
         if_err_q     <= if_err_d;
         if_rdata_q   <= if_rdata_d;
         d_rvalid_q   <= d_rvalid_d;
         d_err_q      <= d_err_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign if_gnt_o    = if_gnt;
   assign d_gnt_o     = d_gnt;
   assign if_rvalid_o = if_rvalid_q;
   assign if_err_o    = if_err_q;
   assign if_rdata_o  = if_rdata_q;
   assign d_rvalid_o  = d_rvalid_q;
   assign d_err_o     = d_err_q;
   assign d_rdata_o   = d_rdata_q;

`ifdef MEM_ARB_STATS_EN
   logic [31:0] stat_if_q, stat_if_d;
   logic [31:0] stat_d_q, stat_d_d;
   logic [31:0] stat_stall_q, stat_stall_d;

   // Free-running counters, wrapping modulo 2^32.
   always_comb begin
      stat_if_d    = stat_if_q + 32'(if_gnt);
      stat_d_d     = stat_d_q + 32'(d_gnt);
      stat_stall_d = stat_stall_q + 32'((if_req_i & ~if_gnt) | (d_req_i & ~d_gnt));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_if_q    <= '0;
         stat_d_q     <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_if_q    <= stat_if_d;
         stat_d_q     <= stat_d_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_if_cnt_o    = stat_if_q;
   assign stat_d_cnt_o     = stat_d_q;
   assign stat_stall_cnt_o = stat_stall_q;
`else
   assign stat_if_cnt_o    = '0;
   assign stat_d_cnt_o     = '0;
   assign stat_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected responses are queued at grant time and
// compared when the registered response appears one cycle later.
module tb_mem_arbiter;

   localparam logic [31:0] BASE = 32'h0100_0000;

   typedef struct packed {
      logic        vld;
      logic        is_d;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = '0;
   logic        if_gnt_o, if_rvalid_o, if_err_o;
   logic [31:0] if_rdata_o;
   logic        d_req_i = 1'b0;
   logic        d_we_i = 1'b0;
   logic [31:0] d_addr_i = '0;
   logic [31:0] d_wdata_i = '0;
   logic        d_gnt_o, d_rvalid_o, d_err_o;
   logic [31:0] d_rdata_o;
   logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
   logic        mem_read_en_o, mem_write_en_o;
   logic [31:0] stat_if_cnt_o, stat_d_cnt_o, stat_stall_cnt_o;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] mem_words [0:255];

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_read_en_o(mem_read_en_o),
      .mem_write_en_o(mem_write_en_o), .mem_data_i(mem_data_i),
      .stat_if_cnt_o(stat_if_cnt_o), .stat_d_cnt_o(stat_d_cnt_o), .stat_stall_cnt_o(stat_stall_cnt_o)
   );

   always #5 clk = ~clk;

   // Memory model: preloaded while in reset, written on the edge closing a write grant.
   always @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 256; k++)
            mem_words[k] <= (k == 0) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | 32'(k));
      end else if (mem_write_en_o) begin
         mem_words[mem_addr_o[9:2]] <= mem_data_o;
      end
   end
   assign mem_data_i = mem_words[mem_addr_o[9:2]];

   task automatic idle_inputs();
      if_req_i = 1'b0; if_addr_i = '0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      if_req_i = 1'b1; if_addr_i = BASE;
      d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = BASE + 32'h4; d_wdata_i = 32'h1234_5678;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (if_gnt_o !== 1'b0 || d_gnt_o !== 1'b0 || mem_read_en_o !== 1'b0 || mem_write_en_o !== 1'b0) begin
         errors++;
         $display("FAIL reset grants: got if_gnt=%b d_gnt=%b rd=%b wr=%b, want all 0",
                  if_gnt_o, d_gnt_o, mem_read_en_o, mem_write_en_o);
      end
      checks++;
      if (if_rvalid_o !== 1'b0 || if_err_o !== 1'b0 || if_rdata_o !== 32'h0 ||
          d_rvalid_o !== 1'b0 || d_err_o !== 1'b0 || d_rdata_o !== 32'h0) begin
         errors++;
         $display("FAIL reset resp: got if(v=%b e=%b d=%h) d(v=%b e=%b d=%h), want all 0",
                  if_rvalid_o, if_err_o, if_rdata_o, d_rvalid_o, d_err_o, d_rdata_o);
      end
      checks++;
      if (mem_addr_o !== BASE || mem_data_o !== 32'h0 ||
          stat_if_cnt_o !== 32'h0 || stat_d_cnt_o !== 32'h0 || stat_stall_cnt_o !== 32'h0) begin
         errors++;
         $display("FAIL reset idle: got addr=%h data=%h stats=%0d/%0d/%0d, want addr=%h data=0 stats 0",
                  mem_addr_o, mem_data_o, stat_if_cnt_o, stat_d_cnt_o, stat_stall_cnt_o, BASE);
      end
      idle_inputs();
      rst = 1'b1;
   endtask

   task automatic test_if_read();
      exp_t e;
      logic w_if, w_d, w_rd, w_wr;
      logic [31:0] w_addr, w_data;
      for (int c = 0; c <= 2; c++) begin
         @(posedge clk); #1;
         if (c > 0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL if_read c%0d: scoreboard empty", c);
            end else begin
               e = sb.pop_front();
               if (if_rvalid_o !== (e.vld & ~e.is_d) || d_rvalid_o !== (e.vld & e.is_d) ||
                   (e.vld && !e.is_d && (if_err_o !== e.err || if_rdata_o !== e.rdata))) begin
                  errors++;
                  $display("FAIL if_read resp c%0d: got if(v=%b e=%b d=%h) d_v=%b, want vld=%b d=%b e=%b d=%h",
                           c, if_rvalid_o, if_err_o, if_rdata_o, d_rvalid_o, e.vld, e.is_d, e.err, e.rdata);
               end
            end
         end
         if (c < 2) begin
            idle_inputs();
            {w_if, w_d, w_rd, w_wr, w_addr, w_data} = {4'b0000, BASE, 32'h0};
            e = '0;
            if (c == 0) begin
               if_req_i = 1'b1; if_addr_i = BASE;
               {w_if, w_rd} = 2'b11;
               e = '{vld: 1'b1, is_d: 1'b0, err: 1'b0, rdata: 32'hDEAD_BEEF};
            end
            #1;
            checks++;
            if (if_gnt_o !== w_if || d_gnt_o !== w_d || mem_read_en_o !== w_rd ||
                mem_write_en_o !== w_wr || mem_addr_o !== w_addr || (!w_rd && mem_data_o !== w_data)) begin
               errors++;
               $display("FAIL if_read gnt c%0d: got gnt=%b%b rd=%b wr=%b addr=%h data=%h, want gnt=%b%b rd=%b wr=%b addr=%h",
                        c, if_gnt_o, d_gnt_o, mem_read_en_o, mem_write_en_o, mem_addr_o, mem_data_o,
                        w_if, w_d, w_rd, w_wr, w_addr);
            end
            sb.push_back(e);
         end
      end
   endtask

   // Both ports request every cycle: with a limit of 4 the grant pattern repeats D,D,D,D,IF.
   task automatic test_priority();
      exp_t e;
      logic w_d;
      logic [31:0] w_si, w_sd, w_ss;
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      for (int c = 0; c <= 11; c++) begin
         @(posedge clk); #1;
         if (c > 0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL priority c%0d: scoreboard empty", c);
            end else begin
               e = sb.pop_front();
               if (if_rvalid_o !== (e.vld & ~e.is_d) || d_rvalid_o !== (e.vld & e.is_d) ||
                   (e.vld && !e.is_d && (if_err_o !== e.err || if_rdata_o !== e.rdata)) ||
                   (e.vld && e.is_d && (d_err_o !== e.err || d_rdata_o !== e.rdata))) begin
                  errors++;
                  $display("FAIL priority resp c%0d: got if(v=%b d=%h) d(v=%b d=%h), want vld=%b is_d=%b d=%h",
                           c, if_rvalid_o, if_rdata_o, d_rvalid_o, d_rdata_o, e.vld, e.is_d, e.rdata);
               end
            end
         end
         if (c < 11) begin
            idle_inputs();
            e = '0;
            w_d = 1'b0;
            if (c < 10) begin
               if_req_i = 1'b1; if_addr_i = BASE + 32'h8;
               d_req_i = 1'b1; d_addr_i = BASE + 32'hC;
               w_d = ((c % 5) != 4);
               e = w_d ? '{vld: 1'b1, is_d: 1'b1, err: 1'b0, rdata: 32'hA5A5_0003}
                       : '{vld: 1'b1, is_d: 1'b0, err: 1'b0, rdata: 32'hA5A5_0002};
            end
            #1;
            checks++;
            if (d_gnt_o !== w_d || if_gnt_o !== (c < 10 && !w_d) ||
                (c < 10 && (mem_read_en_o !== 1'b1 || mem_addr_o !== (w_d ? BASE + 32'hC : BASE + 32'h8)))) begin
               errors++;
               $display("FAIL priority gnt c%0d: got if_gnt=%b d_gnt=%b rd=%b addr=%h, want d_gnt=%b",
                        c, if_gnt_o, d_gnt_o, mem_read_en_o, mem_addr_o, w_d);
            end
            sb.push_back(e);
         end
      end
`ifdef MEM_ARB_STATS_EN
      {w_si, w_sd, w_ss} = {32'd2, 32'd8, 32'd10};
`else
      {w_si, w_sd, w_ss} = {32'd0, 32'd0, 32'd0};
`endif
      checks++;
      if (stat_if_cnt_o !== w_si || stat_d_cnt_o !== w_sd || stat_stall_cnt_o !== w_ss) begin
         errors++;
         $display("FAIL stats: got if=%0d d=%0d stall=%0d, want if=%0d d=%0d stall=%0d",
                  stat_if_cnt_o, stat_d_cnt_o, stat_stall_cnt_o, w_si, w_sd, w_ss);
      end
   endtask

   task automatic test_write_read();
      exp_t e;
      logic w_rd, w_wr;
      for (int c = 0; c <= 3; c++) begin
         @(posedge clk); #1;
         if (c > 0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL write_read c%0d: scoreboard empty", c);
            end else begin
               e = sb.pop_front();
               if (if_rvalid_o !== (e.vld & ~e.is_d) || d_rvalid_o !== (e.vld & e.is_d) ||
                   (e.vld && e.is_d && (d_err_o !== e.err || d_rdata_o !== e.rdata))) begin
                  errors++;
                  $display("FAIL write_read resp c%0d: got d(v=%b e=%b d=%h) if_v=%b, want vld=%b e=%b d=%h",
                           c, d_rvalid_o, d_err_o, d_rdata_o, if_rvalid_o, e.vld, e.err, e.rdata);
               end
            end
         end
         if (c < 3) begin
            idle_inputs();
            e = '0;
            {w_rd, w_wr} = 2'b00;
            if (c < 2) begin
               d_req_i = 1'b1; d_addr_i = BASE + 32'h10;
               d_we_i = (c == 0); d_wdata_i = 32'hCAFE_F00D;
               {w_rd, w_wr} = (c == 0) ? 2'b01 : 2'b10;
               e = '{vld: 1'b1, is_d: 1'b1, err: 1'b0, rdata: (c == 0) ? 32'h0 : 32'hCAFE_F00D};
            end
            #1;
            checks++;
            if (d_gnt_o !== (c < 2) || if_gnt_o !== 1'b0 || mem_read_en_o !== w_rd || mem_write_en_o !== w_wr ||
                mem_addr_o !== ((c < 2) ? BASE + 32'h10 : BASE) ||
                ((w_wr || c == 2) && mem_data_o !== (w_wr ? 32'hCAFE_F00D : 32'h0))) begin
               errors++;
               $display("FAIL write_read gnt c%0d: got d_gnt=%b rd=%b wr=%b addr=%h data=%h, want rd=%b wr=%b",
                        c, d_gnt_o, mem_read_en_o, mem_write_en_o, mem_addr_o, mem_data_o, w_rd, w_wr);
            end
            sb.push_back(e);
         end
      end
   endtask

   // Misaligned, past-the-end and below-base accesses, plus the last legal word.
   task automatic test_errors();
      exp_t e;
      logic w_if, w_d, w_rd;
      for (int c = 0; c <= 5; c++) begin
         @(posedge clk); #1;
         if (c > 0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL errors c%0d: scoreboard empty", c);
            end else begin
               e = sb.pop_front();
               if (if_rvalid_o !== (e.vld & ~e.is_d) || d_rvalid_o !== (e.vld & e.is_d) ||
                   (e.vld && !e.is_d && (if_err_o !== e.err || if_rdata_o !== e.rdata)) ||
                   (e.vld && e.is_d && (d_err_o !== e.err || d_rdata_o !== e.rdata))) begin
                  errors++;
                  $display("FAIL errors resp c%0d: got if(v=%b e=%b d=%h) d(v=%b e=%b d=%h), want vld=%b is_d=%b e=%b d=%h",
                           c, if_rvalid_o, if_err_o, if_rdata_o, d_rvalid_o, d_err_o, d_rdata_o,
                           e.vld, e.is_d, e.err, e.rdata);
               end
            end
         end
         if (c < 5) begin
            idle_inputs();
            e = '0;
            {w_if, w_d, w_rd} = 3'b000;
            case (c)
               0: begin
                  d_req_i = 1'b1; d_addr_i = BASE + 32'h2;
                  if_req_i = 1'b1; if_addr_i = BASE + 32'h0001_0000;
                  w_d = 1'b1;
                  e = '{vld: 1'b1, is_d: 1'b1, err: 1'b1, rdata: 32'h0};
               end
               1: begin
                  if_req_i = 1'b1; if_addr_i = BASE + 32'h0001_0000;
                  w_if = 1'b1;
                  e = '{vld: 1'b1, is_d: 1'b0, err: 1'b1, rdata: 32'h0};
               end
               2: begin
                  if_req_i = 1'b1; if_addr_i = BASE + 32'h0000_FFFC;
                  {w_if, w_rd} = 2'b11;
                  e = '{vld: 1'b1, is_d: 1'b0, err: 1'b0, rdata: 32'hA5A5_00FF};
               end
               3: begin
                  d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = BASE - 32'h4; d_wdata_i = 32'h5555_AAAA;
                  w_d = 1'b1;
                  e = '{vld: 1'b1, is_d: 1'b1, err: 1'b1, rdata: 32'h0};
               end
               default: ;
            endcase
            #1;
            checks++;
            if (if_gnt_o !== w_if || d_gnt_o !== w_d || mem_read_en_o !== w_rd || mem_write_en_o !== 1'b0 ||
                (w_rd && mem_addr_o !== BASE + 32'h0000_FFFC)) begin
               errors++;
               $display("FAIL errors gnt c%0d: got gnt=%b%b rd=%b wr=%b addr=%h, want gnt=%b%b rd=%b wr=0",
                        c, if_gnt_o, d_gnt_o, mem_read_en_o, mem_write_en_o, mem_addr_o, w_if, w_d, w_rd);
            end
            sb.push_back(e);
         end
      end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      idle_inputs();
      if_req_i = 1'b1; if_addr_i = BASE + 32'h4;
      #1;
      checks++;
      if (if_gnt_o !== 1'b1) begin
         errors++; $display("FAIL reset_mid gnt: got if_gnt=%b, want 1", if_gnt_o);
      end
      @(posedge clk); #1;
      idle_inputs();
      checks++;
      if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hA5A5_0001) begin
         errors++;
         $display("FAIL reset_mid pending: got v=%b d=%h, want v=1 d=a5a50001", if_rvalid_o, if_rdata_o);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (if_rvalid_o !== 1'b0 || if_rdata_o !== 32'h0 || if_err_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid drop: got v=%b e=%b d=%h, want all 0", if_rvalid_o, if_err_o, if_rdata_o);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++;
         if (if_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid after c%0d: got if_v=%b d_v=%b, want 0", c, if_rvalid_o, d_rvalid_o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_if_read();
      test_priority();
      test_write_read();
      test_errors();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-addressable unified memory port between the instruction-fetch requester (IF) and the load/store requester (D).
- Fixed priority D > IF with starvation protection; misaligned and out-of-range accesses are rejected with an error response.
- One access per cycle; registered responses one cycle after grant.
- Sits between the core front-end/LSU and the memory block; drives its addr/data/read_en/write_en directly.

Parameters:
AWIDTH, 32, address width
DWIDTH, 32, data width (word access only)
BASE_ADDR, 32'h01000000, first valid byte address
MEM_BYTES, 65536, size of legal window in bytes
STARVE_LIMIT, 4, consecutive IF-wait cycles (IF requesting, not granted) that force an IF grant; must be ≥1

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
if_req_i  in  1  IF read request, held until granted
if_addr_i  in  AWIDTH  IF byte address
if_gnt_o  out  1  IF request accepted this cycle (combinational)
if_rvalid_o  out  1  IF response valid (registered)
if_rdata_o  out  DWIDTH  IF read data
if_err_o  out  1  IF response is an error, qualifies if_rvalid_o
d_req_i  in  1  D request, held until granted
d_we_i  in  1  1 = write, 0 = read
d_addr_i  in  AWIDTH  D byte address
d_wdata_i  in  DWIDTH  D write data
d_gnt_o  out  1  D request accepted this cycle
d_rvalid_o  out  1  D response valid (reads and writes)
d_rdata_o  out  DWIDTH  D read data (0 for writes/errors)
d_err_o  out  1  D response is an error
mem_addr_o  out  AWIDTH  to memory address
mem_data_o  out  DWIDTH  to memory write data
mem_read_en_o  out  1  to memory read enable
mem_write_en_o  out  1  to memory write enable
mem_data_i  in  DWIDTH  from memory combinational read data
stat_if_cnt_o, stat_d_cnt_o, stat_stall_cnt_o  out  32 each  statistics, see Optional Feature

Behaviour:
- Reset (rst=0, async): all rvalid/err/rdata outputs 0, starvation counter 0, stat counters 0. Grants are combinational but forced 0 while rst=0; memory enables 0.
- Grant rule per cycle, at most one:
  - Force IF if if_req_i and starve_cnt ≥ STARVE_LIMIT.
  - Otherwise D if d_req_i.
  - Otherwise IF if if_req_i.
- starve_cnt:
  - Increments (saturating) each cycle if_req_i=1 and IF not granted.
  - Clears on IF grant or when if_req_i=0.
- Legality check on granted address a:
  - Error if a[1:0]≠0, a<BASE_ADDR, or a>BASE_ADDR+MEM_BYTES-4.
- Legal grant, same cycle:
  - mem_addr_o=a.
  - D write: mem_write_en_o=1, mem_data_o=d_wdata_i.
  - Read: mem_read_en_o=1.
- Illegal grant: no memory enable asserted, grant still given (request consumed).
- No grant: mem_addr_o=BASE_ADDR, enables 0, mem_data_o=0.
- Response latency exactly 1 cycle after the grant cycle: the granted port's rvalid=1 for one cycle.
  - rdata = captured mem_data_i for legal reads; otherwise 0.
  - err as computed.
  - Non-granted port's rvalid=0.
- Back-to-back grants every cycle are allowed; no backpressure on responses (requesters must always accept).
- Write followed by read of same word in next cycle returns the new data (memory writes on the edge closing the grant cycle).
- Reset asserted mid-response: response dropped, no rvalid after reset release until a new grant.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined:
  - stat_if_cnt_o counts IF grants.
  - stat_d_cnt_o counts D grants.
  - stat_stall_cnt_o counts cycles with any request not granted.
  - All 32-bit, wrap modulo 2^32, cleared by reset.
- Undefined: the three outputs tied to 0 and no counter flops are inferred; port list unchanged.

Test Plan:
- Reset then IF-only read of 0x01000000 holding 0xDEADBEEF → if_gnt_o=1 cycle 0; if_rvalid_o=1, if_rdata_o=0xDEADBEEF, if_err_o=0 cycle 1.
- Both requesting every cycle, STARVE_LIMIT=4 → D granted cycles 0–3, IF granted cycle 4, D cycle 5; starve_cnt back to 0 after IF grant.
- D write 0xCAFEF00D to 0x01000010 cycle 0, D read same address cycle 1 → d_rvalid_o with d_rdata_o=0xCAFEF00D cycle 2; write response cycle 1 has d_rdata_o=0.
- D read 0x01000002 (misaligned) and IF read 0x01010000 (out of range) → grants given, mem enables stay 0, respective err=1, rdata=0 next cycle.
- Assert rst low while an IF response is pending → if_rvalid_o drops to 0 immediately, stays 0 after release with no requests.
- With MEM_ARB_STATS_EN: 10 cycles both requesting, STARVE_LIMIT=4 → stat_d_cnt_o=8, stat_if_cnt_o=2, stat_stall_cnt_o=10; without macro all three read 0.
